dram_rd_assembler: RTL and testbench

DRAM_RD_ASSEMBLER -- requirements
Module: dram_rd_assembler

---
 rtl/dram_pack.sv | 11 +
 rtl/dram_rd_line_fifo.sv | 61 ++++++
 rtl/dram_rd_assembler.sv | 112 +++++++++++
 tb/tb_dram_rd_assembler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pack.sv
// rtl/dram_pack.sv - shared constants and FSM state type for the DRAM read path
package dram_pack;

   localparam int CONFIGURED_DQ_BITS = 8;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } rd_asm_state_t;

endpackage

// File: rtl/dram_rd_line_fifo.sv
// rtl/dram_rd_line_fifo.sv - small line FIFO with flush, head presented combinationally
module dram_rd_line_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign do_pop   = pop && !empty;
   // When full, a same-cycle pop frees the head slot, which is the slot being written.
   assign do_push  = push && (!full || do_pop);
   // Empty FIFO shows zero so the line output is clean after reset/flush.
   assign pop_data = empty ? '0 : mem[rd_ptr_q];

   // Pointer and occupancy tracking; flush empties the FIFO ahead of any push/pop.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Line storage; contents need no reset because the output is gated by empty.
   always_ff @(posedge CLK) begin
      if (do_push && !flush) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/dram_rd_assembler.sv
// rtl/dram_rd_assembler.sv - assembles captured read beats into burst lines; RDBUF_DBI_EN adds DBI inversion
module dram_rd_assembler
   import dram_pack::*;
#(
   parameter int BURST_LEN  = 8,
   parameter int DQ_W       = CONFIGURED_DQ_BITS,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      clear,
   input  logic                      beat_valid,
   input  logic [DQ_W-1:0]           beat_data,
`ifdef RDBUF_DBI_EN
   input  logic                      beat_dbi_n,
`endif
   output logic                      out_valid,
   output logic [BURST_LEN*DQ_W-1:0] out_data,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      overflow
);

   localparam int LINE_W = BURST_LEN * DQ_W;
   localparam int IDX_W  = $clog2(BURST_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

   rd_asm_state_t     state_q;
   rd_asm_state_t     state_d;
   logic [IDX_W-1:0]  beat_idx_q;
   logic [LINE_W-1:0] line_q;
   logic [LINE_W-1:0] line_d;
   logic [DQ_W-1:0]   beat_word;
   logic              accept;
   logic              last_beat;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow_q;

`ifdef RDBUF_DBI_EN
   assign beat_word = beat_dbi_n ? beat_data : ~beat_data;
`else
   assign beat_word = beat_data;
`endif

   // clear wins over any beat presented in the same cycle.
   assign accept    = beat_valid && !clear;
   assign last_beat = accept && (beat_idx_q == LAST_IDX);
   assign pop       = out_valid && out_ready;
   assign out_valid = !fifo_empty;
   assign overflow  = overflow_q;

   // Partial line with the current beat merged in; on the last beat this is the pushed line.
   always_comb begin
      line_d = line_q;
      line_d[int'(beat_idx_q) * DQ_W +: DQ_W] = beat_word;
   end

   // Next state and busy: a burst opens on its first beat and closes on its last.
   always_comb begin
      state_d = state_q;
      busy    = (state_q == COLLECT);
      case (state_q)
         IDLE:    if (accept)    state_d = COLLECT;
         COLLECT: if (last_beat) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   // FSM state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Beat index, partial line and sticky overflow.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         beat_idx_q <= '0;
         line_q     <= '0;
         overflow_q <= 1'b0;
      end else if (clear) begin
         beat_idx_q <= '0;
         line_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            line_q     <= line_d;
            beat_idx_q <= last_beat ? '0 : beat_idx_q + 1'b1;
         end
         if (last_beat && fifo_full && !pop) overflow_q <= 1'b1;
      end
   end

   dram_rd_line_fifo #(
      .WIDTH (LINE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_line_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (clear),
      .push      (last_beat),
      .push_data (line_d),
      .pop       (pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_dram_rd_assembler.sv
// tb/tb_dram_rd_assembler.sv - directed scoreboard bench for dram_rd_assembler
module tb_dram_rd_assembler;
   import dram_pack::*;

   localparam int BL = 8;
   localparam int DW = CONFIGURED_DQ_BITS;
   localparam int LW = BL * DW;

   logic          CLK = 1'b0;
   logic          RST;
   logic          clear;
   logic          beat_valid;
   logic [DW-1:0] beat_data;
   logic          beat_dbi_n;
   logic          out_valid;
   logic [LW-1:0] out_data;
   logic          out_ready;
   logic          busy;
   logic          overflow;

   int            total = 0;
   int            bad   = 0;
   logic [LW-1:0] sb [$];
   logic [DW-1:0] bt [BL];

   always #5 CLK = ~CLK;

   dram_rd_assembler #(
      .BURST_LEN  (BL),
      .DQ_W       (DW),
      .FIFO_DEPTH (2)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .clear      (clear),
      .beat_valid (beat_valid),
      .beat_data  (beat_data),
`ifdef RDBUF_DBI_EN
      .beat_dbi_n (beat_dbi_n),
`endif
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic dbi_n);
      beat_valid = 1'b1;
      beat_data  = d;
      beat_dbi_n = dbi_n;
      @(posedge CLK);
      #1;
      beat_valid = 1'b0;
      beat_dbi_n = 1'b1;
   endtask

   task automatic send_burst(input logic [DW-1:0] b [BL], input int gap_after, input int gap_len);
      for (int k = 0; k < BL; k++) begin
         send_beat(b[k], 1'b1);
         if (k == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               @(posedge CLK);
               #1;
               check("gap_busy", busy, 1'b1);
            end
         end
      end
   endtask

   task automatic send_seq(input logic [DW-1:0] base, input int nbeats);
      for (int k = 0; k < nbeats; k++) send_beat(base + DW'(k + 1), 1'b1);
   endtask

   task automatic pop_line(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 16) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check({tag, "_valid"}, out_valid, 1'b1);
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL %s_sb: observed=line expected=no line", tag);
      end
      if (sb.size() > 0) check(tag, out_data, sb[0]);
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST        = 1'b0;
      clear      = 1'b0;
      beat_valid = 1'b0;
      beat_data  = '0;
      beat_dbi_n = 1'b1;
      out_ready  = 1'b0;
      #2 RST = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST = 1'b0;
      @(posedge CLK);
      #1;

      // single back-to-back burst with consumer ready
      out_ready = 1'b1;
      bt = '{8'hAB, 8'hCD, 8'hEE, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      sb.push_back(64'hDDCCBBAAFFEECDAB);
      send_beat(bt[0], 1'b1);
      check("t1_busy", busy, 1'b1);
      for (int k = 1; k < BL; k++) send_beat(bt[k], 1'b1);
      check("t1_valid", out_valid, 1'b1);
      check("t1_data", out_data, sb.pop_front());
      check("t1_busy_end", busy, 1'b0);
      @(posedge CLK);
      #1;
      check("t1_valid_drop", out_valid, 1'b0);

      // same burst with a 3-cycle gap after beat 3
      sb.push_back(64'hDDCCBBAAFFEECDAB);
      send_burst(bt, 3, 3);
      check("t2_valid", out_valid, 1'b1);
      check("t2_data", out_data, sb.pop_front());
      @(posedge CLK);
      #1;
      check("t2_valid_drop", out_valid, 1'b0);

      // backpressure: third line dropped, overflow sticky
      out_ready = 1'b0;
      sb.push_back(64'h0807060504030201);
      sb.push_back(64'h1817161514131211);
      send_seq(8'h00, BL);
      send_seq(8'h10, BL);
      send_seq(8'h20, BL);
      check("t3_overflow", overflow, 1'b1);
      check("t3_head", out_data, sb[0]);
      repeat (2) @(posedge CLK);
      #1;
      check("t3_hold", out_data, sb[0]);
      pop_line("t3_line0");
      pop_line("t3_line1");
      check("t3_empty", out_valid, 1'b0);
      check("t3_sticky", overflow, 1'b1);

      // mid-burst abort; the beat on the clear cycle is ignored
      send_seq(8'h90, 4);
      check("t4_busy_pre", busy, 1'b1);
      clear      = 1'b1;
      beat_valid = 1'b1;
      beat_data  = 8'h77;
      @(posedge CLK);
      #1;
      clear      = 1'b0;
      beat_valid = 1'b0;
      check("t4_busy", busy, 1'b0);
      check("t4_overflow", overflow, 1'b0);
      check("t4_valid", out_valid, 1'b0);
      out_ready = 1'b1;
      sb.push_back(64'h0807060504030201);
      send_seq(8'h00, BL);
      check("t4_line_valid", out_valid, 1'b1);
      check("t4_line", out_data, sb.pop_front());
      @(posedge CLK);
      #1;
      out_ready = 1'b0;

      // push and pop in the same cycle while full: no drop
      sb.push_back(64'h0807060504030201);
      sb.push_back(64'h1817161514131211);
      send_seq(8'h00, BL);
      send_seq(8'h10, BL);
      send_seq(8'h20, BL - 1);
      check("t5_head", out_data, sb[0]);
      out_ready = 1'b1;
      send_beat(8'h28, 1'b1);
      out_ready = 1'b0;
      void'(sb.pop_front());
      sb.push_back(64'h2827262524232221);
      check("t5_no_overflow", overflow, 1'b0);
      pop_line("t5_line1");
      pop_line("t5_line2");
      check("t5_empty", out_valid, 1'b0);

      // async reset in the middle of beat 5 with a line waiting
      sb.push_back(64'h0807060504030201);
      send_seq(8'h00, BL);
      check("t6_valid_pre", out_valid, 1'b1);
      send_seq(8'h30, 4);
      beat_valid = 1'b1;
      beat_data  = 8'h35;
      #2 RST = 1'b1;
      #1;
      check("t6_out_valid", out_valid, 1'b0);
      check("t6_out_data", out_data, '0);
      check("t6_busy", busy, 1'b0);
      check("t6_overflow", overflow, 1'b0);
      beat_valid = 1'b0;
      sb.delete();
      @(negedge CLK) RST = 1'b0;
      @(posedge CLK);
      #1;
      out_ready = 1'b1;
      sb.push_back(64'h1817161514131211);
      send_seq(8'h10, BL);
      check("t6_line_valid", out_valid, 1'b1);
      check("t6_line", out_data, sb.pop_front());
      @(posedge CLK);
      #1;
      out_ready = 1'b0;

`ifdef RDBUF_DBI_EN
      // DBI: an inverted beat is restored before storage
      out_ready = 1'b1;
      sb.push_back(64'h00000000000000AB);
      send_beat(8'h54, 1'b0);
      for (int k = 1; k < BL; k++) send_beat(8'h00, 1'b1);
      check("t7_valid", out_valid, 1'b1);
      check("t7_data", out_data, sb.pop_front());
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
